pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the ID/EX pipeline register and its neighbours: per-cycle hold, flush and bubble controls for
//  PC, IF/ID, ID/EX and EX/MEM. Detects load-use and taken-branch hazards, freezes the pipe during memory
//  wait states and drains it before interrupt entry. Sits beside the ID stage; its id_ex_stall drives the
//  ID/EX register's stall input, which zeroes MemWr/MemRd/RegWr to form a bubble.
// PARAMETERS
//  WAIT_MAX     16  max consecutive mem_busy cycles before timeout abort (>=2)
//  DRAIN_CYC    3   bubbles injected before irq_take (covers EX, MEM, WB)
//  CNT_W        16  width of saturating stall-cycle counter
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high
//  id_rs        in   5      ID source register rs
//  id_rt        in   5      ID source register rt
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  ex_memrd     in   1      EX instruction is a load
//  ex_wrreg     in   5      EX resolved destination register
//  ex_br_taken  in   1      EX branch/jump-register resolved taken
//  mem_req      in   1      MEM stage access active
//  mem_busy     in   1      memory not ready this cycle
//  irq          in   1      level interrupt request
//  irq_en       in   1      interrupts enabled
//  pc_hold      out  1      PC keeps value
//  if_id_hold   out  1      IF/ID keeps contents
//  if_id_flush  out  1      IF/ID loads NOP
//  id_ex_stall  out  1      ID/EX loads bubble (control writes zeroed)
//  ex_mem_hold  out  1      EX/MEM keeps contents
//  irq_take     out  1      one-cycle pulse: pipe drained, redirect PC to handler
//  mem_timeout  out  1      sticky: WAIT_MAX exceeded; cleared only by reset
//  stall_cnt    out  CNT_W  saturating count of cycles with pc_hold=1
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, drain_cnt=0, irq_take=0, mem_timeout=0, stall_cnt=0; all combinational
//   controls forced 0 while reset=1.
//  Controls are combinational from registered state + current inputs (act in same cycle); irq_take registered.
//  Load-use (RUN): ex_memrd & ex_wrreg!=0 & ((id_use_rs & id_rs==ex_wrreg)|(id_use_rt & id_rt==ex_wrreg))
//   -> pc_hold=1, if_id_hold=1, id_ex_stall=1 for exactly one cycle (load then leaves EX).
//  Branch (RUN): ex_br_taken -> if_id_flush=1, id_ex_stall=1, no holds. Beats load-use in same cycle.
//  FSM states RUN, MEM_WAIT, IRQ_DRAIN. Priority per cycle: MEM_WAIT freeze > branch > load-use > irq start.
//  RUN -> MEM_WAIT when mem_req & mem_busy; that cycle and every MEM_WAIT cycle with mem_busy=1:
//   pc_hold, if_id_hold, ex_mem_hold =1, id_ex_stall=0 (ID/EX also held via pc/if_id freeze of its inputs
//   is not enough: ID/EX hold is realised by id_ex_stall=0 and if_id_hold=1 only when EX is unchanged,
//   so ID/EX load is gated by ex_mem_hold in the top level). wait_cnt increments each busy cycle.
//  MEM_WAIT -> RUN on mem_busy=0 (controls release same cycle), wait_cnt<=0.
//  MEM_WAIT -> RUN on wait_cnt==WAIT_MAX-1 & mem_busy: mem_timeout<=1, access abandoned, holds released.
//  RUN -> IRQ_DRAIN when irq & irq_en & !ex_br_taken & no load-use & not entering MEM_WAIT
//   (never in a branch shadow). IRQ_DRAIN: pc_hold=1, if_id_hold=1, id_ex_stall=1; drain_cnt counts
//   0..DRAIN_CYC-1; at DRAIN_CYC-1 -> RUN and irq_take<=1 next cycle (single pulse).
//  mem_busy during IRQ_DRAIN: freeze as MEM_WAIT, drain_cnt paused, resume IRQ_DRAIN afterwards
//   (return state latched). irq dropping mid-drain does not abort the drain.
//  stall_cnt increments when pc_hold=1, saturates at all-ones, never wraps.
//  reset mid-operation: all state cleared immediately; pending drain and timeout are lost.
// STRUCTURE
//  Shared package: state encoding (RUN/MEM_WAIT/IRQ_DRAIN), REG_ZERO=5'd0, width constants.
//  One sub-module: hazard_detect_comb (pure load-use compare) instantiated once; FSM, counters local.
// TESTING
//  lw $t0 in EX, ID add uses rs=$t0 -> one cycle pc_hold=if_id_hold=id_ex_stall=1, then all 0.
//  lw to $zero (ex_wrreg=0) with id_rs=0 -> no stall.
//  ex_br_taken=1 with simultaneous load-use -> if_id_flush=1, id_ex_stall=1, pc_hold=0.
//  mem_req & mem_busy for 4 cycles -> 4 cycles freeze, release on 5th, stall_cnt=4, mem_timeout=0.
//  mem_busy held 20 cycles, WAIT_MAX=16 -> release after 16, mem_timeout=1 until reset.
//  irq=1, irq_en=1 in RUN -> 3 bubble cycles, irq_take pulse 1 cycle; same with ex_br_taken -> deferred.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding and
// register-file constants.
package pipeline_hazard_ctrl_pkg;
  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_DRAIN = 2'd2
  } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// Pure combinational load-use compare between the ID source registers and
// the destination of a load currently in EX.
module hazard_detect_comb
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_wrreg,
  output logic             load_use
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_use_rs && (id_rs == ex_wrreg);
  assign rt_hit   = id_use_rt && (id_rt == ex_wrreg);
  assign load_use = ex_memrd && (ex_wrreg != REG_ZERO) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle hold/flush/bubble sequencing for PC, IF/ID, ID/EX and EX/MEM:
// load-use and branch hazards, memory wait freeze, and interrupt drain.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX  = 16,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_wrreg,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_busy,
  input  logic             irq,
  input  logic             irq_en,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             ex_mem_hold,
  output logic             irq_take,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int unsigned WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  hz_state_t           state, state_d, ret_state, ret_d, eff_state;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic [DRAIN_W-1:0]  drain_cnt, drain_d;
  logic                take_d, timeout_d, abandon, abandon_d;
  logic                load_use, freeze;
  logic                pc_h, ifid_h, ifid_f, idex_s, exmem_h;

  hazard_detect_comb u_detect (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_memrd  (ex_memrd),
    .ex_wrreg  (ex_wrreg),
    .load_use  (load_use)
  );

  // The cycle mem_busy drops already behaves as the state being returned to,
  // so holds release (and a paused drain resumes) without a dead cycle.
  always_comb begin
    eff_state = state;
    if (state == ST_MEM_WAIT && !mem_busy) eff_state = ret_state;
  end

  always_comb begin
    state_d   = eff_state;
    ret_d     = ret_state;
    wait_d    = '0;
    drain_d   = drain_cnt;
    take_d    = 1'b0;
    timeout_d = mem_timeout;
    abandon_d = abandon && mem_busy;
    freeze    = 1'b0;
    pc_h      = 1'b0;
    ifid_h    = 1'b0;
    ifid_f    = 1'b0;
    idex_s    = 1'b0;
    exmem_h   = 1'b0;
    unique case (eff_state)
      ST_MEM_WAIT: begin
        freeze = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          state_d   = ST_RUN;
          timeout_d = 1'b1;
          abandon_d = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      ST_IRQ_DRAIN: begin
        if (mem_req && mem_busy && !abandon) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          ret_d   = ST_IRQ_DRAIN;
          wait_d  = wait_cnt + WAIT_W'(1);
        end else begin
          pc_h   = 1'b1;
          ifid_h = 1'b1;
          idex_s = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_d = ST_RUN;
            drain_d = '0;
            take_d  = 1'b1;
          end else begin
            drain_d = drain_cnt + DRAIN_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (mem_req && mem_busy && !abandon) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          ret_d   = ST_RUN;
          wait_d  = wait_cnt + WAIT_W'(1);
        end else if (ex_br_taken) begin
          ifid_f = 1'b1;
          idex_s = 1'b1;
        end else if (load_use) begin
          pc_h   = 1'b1;
          ifid_h = 1'b1;
          idex_s = 1'b1;
        end else if (irq && irq_en) begin
          state_d = ST_IRQ_DRAIN;
          drain_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (freeze) begin
      pc_h    = 1'b1;
      ifid_h  = 1'b1;
      exmem_h = 1'b1;
    end
  end

  assign pc_hold     = pc_h    && !reset;
  assign if_id_hold  = ifid_h  && !reset;
  assign if_id_flush = ifid_f  && !reset;
  assign id_ex_stall = idex_s  && !reset;
  assign ex_mem_hold = exmem_h && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      irq_take    <= 1'b0;
      mem_timeout <= 1'b0;
      abandon     <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_d;
      ret_state   <= ret_d;
      wait_cnt    <= wait_d;
      drain_cnt   <= drain_d;
      irq_take    <= take_d;
      mem_timeout <= timeout_d;
      abandon     <= abandon_d;
      if (pc_hold && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule
